// File: rtl/burst_resp_pkg.sv
// Shared types and constants for the burst responder slice.
package burst_resp_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 8;

    // A programmed max_burst of 0 selects a 256-beat burst.
    localparam logic [8:0] BURST_UNLIMITED = 9'd256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_GAP,
        ST_DONE
    } state_t;

    function automatic logic [8:0] burst_len(input logic [7:0] max_burst);
        return (max_burst == 8'd0) ? BURST_UNLIMITED : {1'b0, max_burst};
    endfunction

endpackage

// File: rtl/burst_resp_mem.sv
// Local byte buffer: one synchronous write port, an asynchronous read port for
// the outbound stream and a registered debug read port.
module burst_resp_mem
    import burst_resp_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_rdata
);

    // Contents are deliberately left out of reset so they survive rst_n.
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata <= '0;
        end else begin
            dbg_rdata <= mem[dbg_addr];
        end
    end

endmodule

// File: rtl/burst_responder.sv
// Target endpoint of the valid/ready/last burst link: stores inbound write
// bursts and streams read bursts back, segmented by the programmed burst size.
module burst_responder
    import burst_resp_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_start,
    input  logic          cmd_rw,
    input  logic [7:0]    cmd_length,
    input  logic [7:0]    cmd_max_burst,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic          err_last,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_rdata
);

    localparam logic [AW-1:0] ADDR_ONE = 1;

    state_t        state_reg;
    logic [7:0]    cnt_reg;
    logic [8:0]    bmax_reg;
    logic [AW-1:0] addr_reg;
    logic [7:0]    beat_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          err_last_reg;
    logic [DW-1:0] m_data_reg;

    logic          last_due;
    logic          mem_we;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;

    // Beat closes a burst when it hits the burst size or is the final beat.
    assign last_due = ({1'b0, beat_reg} == (bmax_reg - 9'd1)) | (cnt_reg == 8'd1);

    assign s_ready = (state_reg == ST_WR);
    assign m_valid = (state_reg == ST_RD);
    assign m_last  = (state_reg == ST_RD) & last_due;

    assign mem_we = (state_reg == ST_WR) & s_valid;
    // Prefetch the next outbound byte so m_data is registered on the handshake.
    assign mem_raddr = (state_reg == ST_IDLE) ? '0 : addr_reg + ADDR_ONE;

    burst_resp_mem #(
        .DW(DW),
        .AW(AW)
    ) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (mem_we),
        .waddr    (addr_reg),
        .wdata    (s_data),
        .raddr    (mem_raddr),
        .rdata    (mem_rdata),
        .dbg_addr (dbg_addr),
        .dbg_rdata(dbg_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            bmax_reg     <= '0;
            addr_reg     <= '0;
            beat_reg     <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            err_last_reg <= 1'b0;
            m_data_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_start) begin
                        cnt_reg      <= cmd_length;
                        bmax_reg     <= burst_len(cmd_max_burst);
                        addr_reg     <= '0;
                        beat_reg     <= '0;
                        err_last_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        if (cmd_length == 8'd0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else if (cmd_rw) begin
                            state_reg <= ST_WR;
                        end else begin
                            state_reg  <= ST_RD;
                            m_data_reg <= mem_rdata;
                        end
                    end
                end
                ST_WR: begin
                    if (s_valid) begin
                        addr_reg <= addr_reg + ADDR_ONE;
                        cnt_reg  <= cnt_reg - 8'd1;
                        beat_reg <= last_due ? 8'd0 : beat_reg + 8'd1;
                        if (s_last != last_due) begin
                            err_last_reg <= 1'b1;
                        end
                        if (cnt_reg == 8'd1) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    if (m_ready) begin
                        addr_reg   <= addr_reg + ADDR_ONE;
                        cnt_reg    <= cnt_reg - 8'd1;
                        beat_reg   <= beat_reg + 8'd1;
                        m_data_reg <= mem_rdata;
                        if (cnt_reg == 8'd1) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else if (last_due) begin
                            state_reg <= ST_RD_GAP;
                        end
                    end
                end
                ST_RD_GAP: begin
                    beat_reg  <= '0;
                    state_reg <= ST_RD;
                end
                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign err_last = err_last_reg;
    assign m_data   = m_data_reg;

endmodule

// File: doc/burst_responder.md
# burst_responder

Target-side endpoint of the 8-bit valid/ready/last burst interface driven by the data burst controller. It accepts write bursts into a local 256-byte buffer and streams read bursts back out, segmenting the stream by a programmed maximum burst size. It sits on the far side of the burst link and also serves as the bench's reference target for the controller.

## Interface
- DW, 8, data width
- AW, 8, buffer address width; depth is 2**AW (256 bytes)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_start  in  1  one-cycle pulse that starts a transaction; sampled only in IDLE
- cmd_rw  in  1  1 = host writes to the responder (inbound), 0 = responder sends (outbound)
- cmd_length  in  8  total beats; latched on cmd_start
- cmd_max_burst  in  8  beats per burst; latched on cmd_start; 0 means 256
- s_valid  in  1  inbound beat valid
- s_data  in  DW  inbound data
- s_last  in  1  inbound last-of-burst flag
- s_ready  out  1  responder accepts an inbound beat
- m_valid  out  1  outbound beat valid
- m_data  out  DW  outbound data
- m_last  out  1  outbound last-of-burst flag
- m_ready  in  1  downstream accepts an outbound beat
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- err_last  out  1  sticky s_last mismatch flag; cleared on cmd_start
- dbg_addr  in  AW  buffer readback address
- dbg_rdata  out  DW  mem[dbg_addr], registered, 1-cycle latency

## Operation
- States: IDLE, WR, RD, RD_GAP, DONE.
- IDLE, cmd_start=1: latch length into cnt and max_burst into bmax; clear addr, beat and err_last; set busy. cmd_length=0 goes to DONE. Otherwise cmd_rw=1 goes to WR, and cmd_rw=0 goes to RD, with m_data<=mem[0] loaded in the same cycle.
- WR: s_ready=1. On each s_valid&s_ready: mem[addr]<=s_data, addr++, cnt--, beat++.
  - Expected last = (beat==bmax-1) | (cnt==1). If s_last differs from expected, set err_last; the transfer continues.
  - Beat resets to 0 at the end of each burst.
  - The handshake with cnt==1 goes to DONE.
- RD: m_valid=1; m_last = (beat==bmax-1) | (cnt==1). On each m_valid&m_ready: addr++, cnt--, m_data<=mem[addr+1]. Then:
  - cnt==1 goes to DONE.
  - m_last=1 goes to RD_GAP.
  - Otherwise stay in RD.
- RD_GAP: m_valid=0 for exactly one cycle, beat cleared, then back to RD.
- DONE: done=1 for one cycle. busy=0 from the next cycle. Next state IDLE.
- cmd_start outside IDLE is ignored. s_valid outside WR is not accepted (s_ready=0).
- addr wraps modulo 2**AW. cnt and beat are 8-bit; bmax is 9-bit internally so that 0 maps to 256.

## Timing
- Reset values: s_ready=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0, err_last=0, dbg_rdata=0, state IDLE.
- Buffer contents are not reset and survive rst_n.
- All outputs are registered except s_ready, m_valid and m_last, which are decoded from the state and registered counters only (no input-to-output combinational path).
- Inbound: first beat accepted in the cycle after cmd_start; throughput 1 beat/cycle.
- Outbound: m_valid first high in the cycle after cmd_start. Within a burst, 1 beat/cycle under continuous m_ready. Exactly one idle cycle between bursts.
- m_data, m_last and m_valid hold stable while m_valid=1 & m_ready=0.
- The done pulse is 1 cycle after the final handshake.
- rst_n asserted mid-transaction aborts immediately. After release: IDLE, no partial outputs, and the next cmd_start behaves normally.

## Structure
- Package burst_resp_pkg holds the state enum, DW/AW defaults, and a BURST_UNLIMITED constant (0 maps to 256).
- Sub-module burst_resp_mem: 2**AW x DW register array with one synchronous write port, one asynchronous read port (outbound path) and one registered read port (dbg).
- The FSM and counters stay in burst_responder.

## Test plan
- Inbound write, length=5, max_burst=2, data 0x10..0x14, s_last on beats 2, 4, 5 -> done 1 cycle after the last beat; err_last=0; dbg reads back 0x10..0x14 at addresses 0..4.
- Same write with s_last on beat 3 only -> err_last=1, data still stored; next cmd_start clears err_last.
- Outbound read, length=5, max_burst=2, m_ready=1 -> beats 0x10,0x11 (m_last on 0x11), gap, 0x12,0x13 (m_last), gap, 0x14 (m_last); done next cycle.
- Outbound with m_ready toggled 1,0,0,1 -> m_data/m_last held during stall, no beat lost or duplicated.
- length=0 -> DONE the cycle after start; no s_ready or m_valid asserted. max_burst=0 with length=255 -> single burst, m_last on beat 255 only.
- rst_n pulsed after beat 2 of an 8-beat write -> outputs at reset values. A following read of length 2 returns the previously stored bytes at addresses 0 and 1.
